// File: rtl/text_console.sv
// Text-mode RAM sequencer: accepts PUT/NEWLINE/CLEAR/HOME commands, tracks the cursor
// and treats the tram as a circular line buffer whose top line is scroll_offs.
module text_console #(
  parameter int WORD      = 32,
  parameter int BYTE_CNT  = 4,
  parameter int ADDRW     = 11,
  parameter int TEXT_HRES = 84,
  parameter int TEXT_VRES = 24,
  parameter logic [WORD-1:0] CLEAR_WORD = 32'h0
) (
  input  logic                clk_sys,
  input  logic                rst_sys,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [WORD-1:0]     cmd_data,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [ADDRW-1:0]    cur_x,
  output logic [ADDRW-1:0]    cur_y,
  output logic                busy
);

  localparam int DEPTH = TEXT_HRES * TEXT_VRES;
  localparam logic [ADDRW:0]   DEPTH_C = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0]   HRES_C  = (ADDRW+1)'(TEXT_HRES);
  localparam logic [ADDRW-1:0] HRES_A  = ADDRW'(TEXT_HRES);
  localparam logic [ADDRW-1:0] LAST_X  = ADDRW'(TEXT_HRES - 1);
  localparam logic [ADDRW-1:0] LAST_Y  = ADDRW'(TEXT_VRES - 1);
  localparam logic [ADDRW-1:0] ONE_A   = {{(ADDRW-1){1'b0}}, 1'b1};
  localparam logic [ADDRW:0]   ONE_C   = {{ADDRW{1'b0}}, 1'b1};
  localparam logic [BYTE_CNT-1:0] WE_ALL = {BYTE_CNT{1'b1}};

  localparam logic [1:0] OP_PUT     = 2'd0;
  localparam logic [1:0] OP_NEWLINE = 2'd1;
  localparam logic [1:0] OP_CLEAR   = 2'd2;
  localparam logic [1:0] OP_HOME    = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, CLRLINE = 2'd2, CLRALL = 2'd3} state_t;

  state_t               state, state_nxt;
  logic [ADDRW-1:0]     row_base, row_nxt, scroll_nxt, x_nxt, y_nxt, addr_nxt;
  logic [ADDRW:0]       cnt, cnt_nxt;
  logic                 scroll_pend, pend_nxt;
  logic [BYTE_CNT-1:0]  we_nxt;
  logic [WORD-1:0]      din_nxt;
  logic                 accept;

  // Modular address add; operands are always below DEPTH so one subtract suffices.
  function automatic logic [ADDRW-1:0] add_mod(input logic [ADDRW-1:0] a, input logic [ADDRW-1:0] b);
    logic [ADDRW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_C) begin
      s = s - DEPTH_C;
    end else begin
      s = s;
    end
    return s[ADDRW-1:0];
  endfunction

  assign cmd_ready = (state == IDLE) && !rst_sys;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUT:     state_nxt = WRITE;
            OP_NEWLINE: state_nxt = (cur_y < LAST_Y) ? IDLE : CLRLINE;
            OP_CLEAR:   state_nxt = CLRALL;
            OP_HOME:    state_nxt = IDLE;
            default:    state_nxt = IDLE;
          endcase
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE:   state_nxt = scroll_pend ? CLRLINE : IDLE;
      CLRLINE: state_nxt = (cnt < HRES_C) ? CLRLINE : IDLE;
      CLRALL:  state_nxt = (cnt < DEPTH_C) ? CLRALL : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the cursor, scroll and tram write port registers.
  always_comb begin
    we_nxt     = '0;
    addr_nxt   = tram_addr;
    din_nxt    = tram_din;
    row_nxt    = row_base;
    scroll_nxt = scroll_offs;
    x_nxt      = cur_x;
    y_nxt      = cur_y;
    pend_nxt   = scroll_pend;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_PUT: begin
              we_nxt   = WE_ALL;
              addr_nxt = add_mod(row_base, cur_x);
              din_nxt  = cmd_data;
              if (cur_x < LAST_X) begin
                x_nxt    = cur_x + ONE_A;
                pend_nxt = 1'b0;
              end else begin
                x_nxt   = '0;
                row_nxt = add_mod(row_base, HRES_A);
                if (cur_y < LAST_Y) begin
                  y_nxt    = cur_y + ONE_A;
                  pend_nxt = 1'b0;
                end else begin
                  pend_nxt = 1'b1;
                end
              end
            end
            OP_NEWLINE: begin
              x_nxt   = '0;
              row_nxt = add_mod(row_base, HRES_A);
              if (cur_y < LAST_Y) begin
                y_nxt = cur_y + ONE_A;
              end else begin
                // The line being scrolled away becomes the new cursor line; clear it.
                we_nxt   = WE_ALL;
                addr_nxt = add_mod(row_base, HRES_A);
                din_nxt  = CLEAR_WORD;
                cnt_nxt  = ONE_C;
              end
            end
            OP_CLEAR: begin
              we_nxt   = WE_ALL;
              addr_nxt = '0;
              din_nxt  = CLEAR_WORD;
              cnt_nxt  = ONE_C;
            end
            OP_HOME: begin
              x_nxt   = '0;
              y_nxt   = '0;
              row_nxt = scroll_offs;
            end
            default: begin
              x_nxt = cur_x;
            end
          endcase
        end else begin
          cnt_nxt = cnt;
        end
      end
      WRITE: begin
        if (scroll_pend) begin
          we_nxt   = WE_ALL;
          addr_nxt = row_base;
          din_nxt  = CLEAR_WORD;
          cnt_nxt  = ONE_C;
          pend_nxt = 1'b0;
        end else begin
          pend_nxt = 1'b0;
        end
      end
      CLRLINE: begin
        if (cnt < HRES_C) begin
          we_nxt   = WE_ALL;
          addr_nxt = add_mod(row_base, cnt[ADDRW-1:0]);
          din_nxt  = CLEAR_WORD;
          cnt_nxt  = cnt + ONE_C;
        end else begin
          scroll_nxt = add_mod(scroll_offs, HRES_A);
          cnt_nxt    = '0;
        end
      end
      CLRALL: begin
        if (cnt < DEPTH_C) begin
          we_nxt   = WE_ALL;
          addr_nxt = cnt[ADDRW-1:0];
          din_nxt  = CLEAR_WORD;
          cnt_nxt  = cnt + ONE_C;
        end else begin
          scroll_nxt = '0;
          row_nxt    = '0;
          x_nxt      = '0;
          y_nxt      = '0;
          cnt_nxt    = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      tram_we     <= '0;
      tram_addr   <= '0;
      tram_din    <= '0;
      row_base    <= '0;
      scroll_offs <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      scroll_pend <= 1'b0;
      cnt         <= '0;
    end else begin
      tram_we     <= we_nxt;
      tram_addr   <= addr_nxt;
      tram_din    <= din_nxt;
      row_base    <= row_nxt;
      scroll_offs <= scroll_nxt;
      cur_x       <= x_nxt;
      cur_y       <= y_nxt;
      scroll_pend <= pend_nxt;
      cnt         <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Randomized self-checking bench for text_console against a line-buffer console model.
module tb_text_console;
  localparam int WORD = 32;
  localparam int BYTE_CNT = 4;
  localparam int ADDRW = 11;
  localparam int H = 84;
  localparam int V = 24;
  localparam int D = H * V;

  logic                clk_sys = 1'b0;
  logic                rst_sys = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = 2'd0;
  logic [WORD-1:0]     cmd_data = 32'h0;
  logic [BYTE_CNT-1:0] tram_we;
  logic [ADDRW-1:0]    tram_addr;
  logic [WORD-1:0]     tram_din;
  logic [ADDRW-1:0]    scroll_offs;
  logic [ADDRW-1:0]    cur_x;
  logic [ADDRW-1:0]    cur_y;
  logic                busy;

  text_console #(
    .WORD(WORD), .BYTE_CNT(BYTE_CNT), .ADDRW(ADDRW),
    .TEXT_HRES(H), .TEXT_VRES(V), .CLEAR_WORD(32'h0)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
    .scroll_offs(scroll_offs), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int bad_addr = 0;
  int bad_we = 0;

  int obs_addr[$];
  int obs_din[$];
  int obs_cyc[$];
  int exp_addr[$];
  int exp_din[$];
  int exp_off[$];

  // Console model: cursor, line base and scroll offset as plain integers.
  int mx = 0, my = 0, mrow = 0, mscroll = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Capture every tram write with the cycle it is presented in.
  always @(negedge clk_sys) begin
    if (tram_we != 4'h0) begin
      if (tram_we != 4'hF) bad_we++;
      if (int'(tram_addr) >= D) bad_addr++;
      obs_addr.push_back(int'(tram_addr));
      obs_din.push_back(int'(tram_din));
      obs_cyc.push_back(cyc);
    end
  end

  task automatic push_exp(input int a, input int d, input int off);
    exp_addr.push_back(a);
    exp_din.push_back(d);
    exp_off.push_back(off);
  endtask

  task automatic model_cmd(input int op, input int data, output int lat);
    case (op)
      0: begin
        push_exp((mrow + mx) % D, data, 1);
        lat = 2;
        if (mx < H - 1) begin
          mx++;
        end else begin
          mx = 0;
          mrow = (mrow + H) % D;
          if (my < V - 1) begin
            my++;
          end else begin
            for (int i = 0; i < H; i++) push_exp(mrow + i, 0, 2 + i);
            mscroll = (mscroll + H) % D;
            lat = H + 2;
          end
        end
      end
      1: begin
        mx = 0;
        mrow = (mrow + H) % D;
        lat = 1;
        if (my < V - 1) begin
          my++;
        end else begin
          for (int i = 0; i < H; i++) push_exp(mrow + i, 0, 1 + i);
          mscroll = (mscroll + H) % D;
          lat = H + 1;
        end
      end
      2: begin
        for (int i = 0; i < D; i++) push_exp(i, 0, 1 + i);
        mx = 0; my = 0; mrow = 0; mscroll = 0;
        lat = D + 1;
      end
      default: begin
        mx = 0; my = 0; mrow = mscroll;
        lat = 1;
      end
    endcase
  endtask

  // Issue one command (entered just after a falling edge) and check it against the model.
  task automatic do_cmd(input int op, input int data);
    int lat_exp, lat, acc, pre_x, pre_y, e0;
    cmd_op = op[1:0];
    cmd_data = data;
    cmd_valid = 1'b1;
    for (int w = 0; w < 5000 && cmd_ready !== 1'b1; w++) begin
      @(negedge clk_sys);
      #1;
    end
    if (cmd_ready !== 1'b1) begin
      check("accept_timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc;
    obs_addr.delete(); obs_din.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_din.delete(); exp_off.delete();
    pre_x = mx; pre_y = my;
    model_cmd(op, data, lat_exp);
    lat = 0;
    for (int k = 1; k <= D + 200; k++) begin
      @(negedge clk_sys);
      #1;
      if (k == 1) begin
        cmd_valid = 1'b0;
        check("busy_n1", busy, lat_exp > 1);
        check("curx_n1", cur_x, (op == 2) ? pre_x : mx);
        check("cury_n1", cur_y, (op == 2) ? pre_y : my);
      end
      if (cmd_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("ready_latency", lat, lat_exp);
    check("write_count", obs_addr.size(), exp_addr.size());
    if (obs_addr.size() == exp_addr.size()) begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        e0 = n_err;
        check("wr_addr", obs_addr[i], exp_addr[i]);
        check("wr_din", obs_din[i], exp_din[i]);
        check("wr_cycle", obs_cyc[i] - acc, exp_off[i]);
        if (n_err != e0) break;
      end
    end
    check("cur_x", cur_x, mx);
    check("cur_y", cur_y, my);
    check("scroll_offs", scroll_offs, mscroll);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_we"}, tram_we, 0);
    check({tag, "_addr"}, tram_addr, 0);
    check({tag, "_din"}, tram_din, 0);
    check({tag, "_scroll"}, scroll_offs, 0);
    check({tag, "_curx"}, cur_x, 0);
    check({tag, "_cury"}, cur_y, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cmd_ready, 0);
  endtask

  initial begin
    int r, w;
    repeat (3) @(negedge clk_sys);
    check_zero_outputs("reset");
    rst_sys = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    // Home-position put, then a full line and one more cell.
    do_cmd(0, 32'h41);
    do_cmd(3, 0);
    for (int i = 0; i < H; i++) do_cmd(0, 32'h42);
    do_cmd(0, 32'h43);

    // Walk to the bottom line and force the first scroll.
    do_cmd(3, 0);
    for (int i = 0; i < V; i++) do_cmd(1, 0);
    do_cmd(0, 32'h44);
    do_cmd(1, 0);

    // A full revolution of scrolls wraps scroll_offs back around.
    for (int i = 0; i < V; i++) do_cmd(1, 0);
    // Fill the bottom line so the last-column put scrolls.
    for (int i = 0; i < H; i++) do_cmd(0, int'($urandom()));

    do_cmd(2, 0);

    for (int n = 0; n < 250; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      #1;
      r = $urandom_range(0, 99);
      if (r < 68) do_cmd(0, int'($urandom()));
      else if (r < 88) do_cmd(1, 0);
      else if (r < 97) do_cmd(3, 0);
      else do_cmd(2, 0);
    end

    // Reset in the middle of a full clear.
    @(negedge clk_sys);
    #1;
    cmd_op = 2'd2;
    cmd_valid = 1'b1;
    obs_addr.delete(); obs_din.delete(); obs_cyc.delete();
    w = 0;
    while (obs_addr.size() < 40 && w < 5000) begin
      @(negedge clk_sys);
      #1;
      cmd_valid = 1'b0;
      w++;
    end
    check("clear_write_40_seen", obs_addr.size(), 40);
    rst_sys = 1'b1;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
    mx = 0; my = 0; mrow = 0; mscroll = 0;
    #1;
    do_cmd(0, 32'h55);

    check("addr_out_of_range", bad_addr, 0);
    check("partial_we", bad_we, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
